// File: rtl/cabletest_pkg.sv
// Shared widths and FSM encoding for the cable-test pattern source.
package cabletest_pkg;
  localparam int DW     = 512;
  localparam int KW     = DW / 8;
  localparam int LANE_W = 32;
  localparam int LANES  = DW / LANE_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/axis_fork2.sv
// Presents one beat to two AXI-Stream sinks and retires it once both have taken it.
// Handshake: a stream's beat transfers on a clock edge where its tvalid and tready are both 1;
// tvalid is a function of registered state only and never of the same-cycle tready.
module axis_fork2 (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic tready_o,
  input  logic tready_f,
  output logic tvalid_o,
  output logic tvalid_f,
  output logic retire
);
  logic taken_o, taken_f;
  logic hs_o, hs_f;

  assign tvalid_o = active & ~taken_o;
  assign tvalid_f = active & ~taken_f;
  assign hs_o     = tvalid_o & tready_o;
  assign hs_f     = tvalid_f & tready_f;
  // A stream is satisfied if it accepted earlier or is accepting now.
  assign retire   = active & (taken_o | hs_o) & (taken_f | hs_f);

  always_ff @(posedge clk) begin
    if (reset || retire || !active) begin
      taken_o <= 1'b0;
      taken_f <= 1'b0;
    end else begin
      taken_o <= taken_o | hs_o;
      taken_f <= taken_f | hs_f;
    end
  end
endmodule

// File: rtl/pattern_transmitter.sv
// Cable-test packet source: counting-pattern packets duplicated onto the link and
// expected-data streams, with run control (start/stop/count) and a sent-packet counter.
module pattern_transmitter
  import cabletest_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  packet_beats,
  input  logic [CNT_W-1:0]  packet_count,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  packets_sent,
  output logic [DW-1:0]     AXIS_OUT_TDATA,
  output logic [KW-1:0]     AXIS_OUT_TKEEP,
  output logic              AXIS_OUT_TLAST,
  output logic              AXIS_OUT_TVALID,
  input  logic              AXIS_OUT_TREADY,
  output logic [DW-1:0]     AXIS_FIFO_OUT_TDATA,
  output logic [KW-1:0]     AXIS_FIFO_OUT_TKEEP,
  output logic              AXIS_FIFO_OUT_TLAST,
  output logic              AXIS_FIFO_OUT_TVALID,
  input  logic              AXIS_FIFO_OUT_TREADY,
  output state_e            state_dbg
);
  state_e            state, state_d;
  logic [LEN_W-1:0]  len_q, beat;
  logic [CNT_W-1:0]  count_q, sent_inc;
  logic [31:0]       word_ctr;
  logic              stop_pending;
  logic              retire, tlast, count_hit, end_run;
  logic [DW-1:0]     tdata;

  axis_fork2 u_fork (
    .clk      (clk),
    .reset    (reset),
    .active   (state == SEND),
    .tready_o (AXIS_OUT_TREADY),
    .tready_f (AXIS_FIFO_OUT_TREADY),
    .tvalid_o (AXIS_OUT_TVALID),
    .tvalid_f (AXIS_FIFO_OUT_TVALID),
    .retire   (retire)
  );

  assign tlast     = (beat == len_q - LEN_W'(1));
  assign sent_inc  = packets_sent + CNT_W'(1);
  assign count_hit = (count_q != '0) && (sent_inc == count_q);
  // A stop arriving on the TLAST retire cycle ends the run at that packet.
  assign end_run   = retire & tlast & (stop_pending | stop | count_hit);

  always_comb begin
    tdata = '0;
    for (int i = 0; i < LANES; i++) begin
      tdata[i*LANE_W +: LANE_W] = word_ctr + 32'(i);
    end
  end

  assign AXIS_OUT_TDATA      = tdata;
  assign AXIS_OUT_TKEEP      = '1;
  assign AXIS_OUT_TLAST      = tlast;
  assign AXIS_FIFO_OUT_TDATA = tdata;
  assign AXIS_FIFO_OUT_TKEEP = '1;
  assign AXIS_FIFO_OUT_TLAST = tlast;
  assign busy                = (state == SEND);
  assign state_dbg           = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (end_run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= LEN_W'(1);
      count_q      <= '0;
      packets_sent <= '0;
      word_ctr     <= '0;
      beat         <= '0;
      stop_pending <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= end_run;
      if (state == IDLE) begin
        if (start) begin
          len_q        <= (packet_beats == '0) ? LEN_W'(1) : packet_beats;
          count_q      <= packet_count;
          packets_sent <= '0;
          word_ctr     <= '0;
          beat         <= '0;
          stop_pending <= stop;
        end
      end else begin
        if (stop) stop_pending <= 1'b1;
        if (retire) begin
          word_ctr <= word_ctr + 32'(LANES);
          if (tlast) begin
            beat <= '0;
            // Saturate so continuous runs never wrap back to zero.
            if (packets_sent != '1) packets_sent <= sent_inc;
          end else begin
            beat <= beat + LEN_W'(1);
          end
        end
        if (end_run) stop_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pattern_transmitter.sv
// Bench for pattern_transmitter: scoreboarded dual-stream capture with directed and random backpressure.
module tb_pattern_transmitter;
  import cabletest_pkg::*;

  localparam int LEN_W = 16;
  localparam int CNT_W = 32;
  localparam int BW    = DW + 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic              stop;
  logic [LEN_W-1:0]  packet_beats;
  logic [CNT_W-1:0]  packet_count;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  packets_sent;
  logic [DW-1:0]     o_tdata, f_tdata;
  logic [KW-1:0]     o_tkeep, f_tkeep;
  logic              o_tlast, f_tlast, o_tvalid, f_tvalid;
  logic              o_tready = 1'b1;
  logic              f_tready = 1'b1;
  state_e            state_dbg;

  pattern_transmitter #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .stop                 (stop),
    .packet_beats         (packet_beats),
    .packet_count         (packet_count),
    .busy                 (busy),
    .done                 (done),
    .packets_sent         (packets_sent),
    .AXIS_OUT_TDATA       (o_tdata),
    .AXIS_OUT_TKEEP       (o_tkeep),
    .AXIS_OUT_TLAST       (o_tlast),
    .AXIS_OUT_TVALID      (o_tvalid),
    .AXIS_OUT_TREADY      (o_tready),
    .AXIS_FIFO_OUT_TDATA  (f_tdata),
    .AXIS_FIFO_OUT_TKEEP  (f_tkeep),
    .AXIS_FIFO_OUT_TLAST  (f_tlast),
    .AXIS_FIFO_OUT_TVALID (f_tvalid),
    .AXIS_FIFO_OUT_TREADY (f_tready),
    .state_dbg            (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_o[$];
  logic [DW:0] exp_f[$];
  int hs_o_cnt = 0;
  int hs_f_cnt = 0;
  int last_hs_cyc = 0;
  int start_cyc = 0;
  int rdy_mode = 0;
  logic hold_o = 1'b0, hold_f = 1'b0;
  logic [DW:0] held_o, held_f;

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] make_beat(input logic [31:0] w, input logic last);
    logic [DW:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = w + 32'(i);
    d[DW] = last;
    return d;
  endfunction

  task automatic push_run(input int beats, input int npkts);
    int len;
    logic [31:0] w;
    len = (beats == 0) ? 1 : beats;
    w = 32'd0;
    for (int p = 0; p < npkts; p++) begin
      for (int b = 0; b < len; b++) begin
        exp_o.push_back(make_beat(w, b == len - 1));
        exp_f.push_back(make_beat(w, b == len - 1));
        w = w + 32'(LANES);
      end
    end
  endtask

  // ready driver: 0 = both ready, 1 = link stalled, 2 = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin o_tready = 1'b1; f_tready = 1'b1; end
      1: begin o_tready = 1'b0; f_tready = 1'b1; end
      default: begin
        o_tready = 1'($urandom_range(0, 1));
        f_tready = 1'($urandom_range(0, 1));
      end
    endcase
  end

  // monitor: compare every handshake and check payload holds while stalled
  always @(negedge clk) begin
    if (reset) begin
      hold_o = 1'b0;
      hold_f = 1'b0;
    end else begin
      if (hold_o) begin
        check("hold_o_valid", BW'(o_tvalid), BW'(1));
        check("hold_o_data", {o_tlast, o_tdata}, held_o);
      end
      if (hold_f) begin
        check("hold_f_valid", BW'(f_tvalid), BW'(1));
        check("hold_f_data", {f_tlast, f_tdata}, held_f);
      end
      hold_o = o_tvalid & ~o_tready;
      hold_f = f_tvalid & ~f_tready;
      held_o = {o_tlast, o_tdata};
      held_f = {f_tlast, f_tdata};
      if (o_tvalid && o_tready) begin
        hs_o_cnt++;
        last_hs_cyc = cyc;
        check("keep_o", BW'(o_tkeep), BW'({KW{1'b1}}));
        if (exp_o.size() == 0) check("extra_o", BW'(1), BW'(0));
        else check("beat_o", {o_tlast, o_tdata}, exp_o.pop_front());
      end
      if (f_tvalid && f_tready) begin
        hs_f_cnt++;
        check("keep_f", BW'(f_tkeep), BW'({KW{1'b1}}));
        if (exp_f.size() == 0) check("extra_f", BW'(1), BW'(0));
        else check("beat_f", {f_tlast, f_tdata}, exp_f.pop_front());
      end
    end
  end

  // driver tasks
  task automatic do_start(input int beats, input int count, input logic stp);
    @(posedge clk); #1;
    start = 1'b1;
    stop = stp;
    packet_beats = LEN_W'(beats);
    packet_count = CNT_W'(count);
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    start_cyc = cyc;
    check("start_busy", BW'(busy), BW'(1));
    check("start_tvalid", BW'(o_tvalid), BW'(1));
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    done_cyc = cyc;
    check("done_seen", BW'(done), BW'(1));
  endtask

  initial begin
    int dc, base_o, base_f;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    packet_beats = '0;
    packet_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", BW'(busy), BW'(0));
    check("rst_done", BW'(done), BW'(0));
    check("rst_sent", BW'(packets_sent), BW'(0));
    check("rst_tvalid_o", BW'(o_tvalid), BW'(0));
    check("rst_tvalid_f", BW'(f_tvalid), BW'(0));
    check("rst_state", BW'(state_dbg), BW'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: back-to-back beats, two packets of four
    base_o = hs_o_cnt;
    push_run(4, 2);
    do_start(4, 2, 1'b0);
    wait_done(100, dc);
    check("t1_done_cyc", BW'(dc), BW'(start_cyc + 8));
    check("t1_last_hs", BW'(last_hs_cyc), BW'(start_cyc + 7));
    check("t1_beats", BW'(hs_o_cnt - base_o), BW'(8));
    check("t1_sent", BW'(packets_sent), BW'(2));
    @(negedge clk);
    check("t1_done_pulse", BW'(done), BW'(0));
    check("t1_idle", BW'(busy), BW'(0));
    check("t1_sent_hold", BW'(packets_sent), BW'(2));

    // 2: link stalled three cycles while the FIFO side is ready
    rdy_mode = 1;
    push_run(4, 1);
    base_o = hs_o_cnt;
    base_f = hs_f_cnt;
    do_start(4, 1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rdy_mode = 0;
    check("t2_fifo_hs", BW'(hs_f_cnt - base_f), BW'(1));
    check("t2_link_hs", BW'(hs_o_cnt - base_o), BW'(0));
    wait_done(100, dc);
    check("t2_sent", BW'(packets_sent), BW'(1));

    // 3: continuous run, stop during beat 2 of 8
    push_run(8, 1);
    do_start(8, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(100, dc);
    check("t3_sent", BW'(packets_sent), BW'(1));

    // 5: reset mid-packet
    push_run(8, 1);
    do_start(8, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_tvalid_o", BW'(o_tvalid), BW'(0));
    check("t5_tvalid_f", BW'(f_tvalid), BW'(0));
    check("t5_busy", BW'(busy), BW'(0));
    check("t5_sent", BW'(packets_sent), BW'(0));
    reset = 1'b0;
    exp_o.delete();
    exp_f.delete();

    // 4: zero length means single-beat packets; also checks restart from lane0 = 0
    base_o = hs_o_cnt;
    push_run(0, 3);
    do_start(0, 3, 1'b0);
    wait_done(100, dc);
    check("t4_beats", BW'(hs_o_cnt - base_o), BW'(3));
    check("t4_sent", BW'(packets_sent), BW'(3));

    // 6: random independent backpressure, 1000 beats
    rdy_mode = 2;
    base_o = hs_o_cnt;
    base_f = hs_f_cnt;
    push_run(10, 100);
    do_start(10, 100, 1'b0);
    wait_done(20000, dc);
    rdy_mode = 0;
    check("t6_sent", BW'(packets_sent), BW'(100));
    check("t6_beats_o", BW'(hs_o_cnt - base_o), BW'(1000));
    check("t6_beats_f", BW'(hs_f_cnt - base_f), BW'(1000));

    repeat (3) @(negedge clk);
    check("left_o", BW'(exp_o.size()), BW'(0));
    check("left_f", BW'(exp_f.size()), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
